aes_ctr_header_framer: RTL and testbench
========================================

AES_CTR_HEADER_FRAMER -- requirements
Module: aes_ctr_header_framer

Interface
REQ-001 Parameter AXIS_WIDTH, default 64; stream data width in bits, legal values 64 and 128 only.
REQ-002 Parameter ENCRYPT_FLAG, default 1; value driven on M_axis_tuser for every output beat.
REQ-003 Clk  input  1  clock; all logic on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Cfg_valid  input  1  new key/IV offered.
REQ-006 Cfg_ready  output  1  config accepted when Cfg_valid & Cfg_ready.
REQ-007 Cfg_key  input  256  AES-256 key; byte i at [8i+7:8i].
REQ-008 Cfg_iv  input  128  initial counter block; byte i at [8i+7:8i].
REQ-009 S_axis_tvalid / S_axis_tready  input / output  1 / 1  payload handshake.
REQ-010 S_axis_tdata / S_axis_tkeep / S_axis_tlast  input  AXIS_WIDTH / AXIS_WIDTH/8 / 1  payload beat.
REQ-011 M_axis_tvalid / M_axis_tready  output / input  1 / 1  framed-stream handshake toward CTR core.
REQ-012 M_axis_tdata / M_axis_tkeep / M_axis_tlast / M_axis_tuser  output  AXIS_WIDTH / AXIS_WIDTH/8 / 1 / 1  framed beat.
REQ-013 Busy  output  1  high in any state other than IDLE.
REQ-014 Pkt_count  output  16  number of completed packets (tlast handshakes on M side), wraps 0xFFFF->0x0000.

Function
REQ-015 States: IDLE, KEY, IV, PAYLOAD; one-hot encoding.
REQ-016 Internal cfg_loaded flag; set on config handshake, cleared only by reset.
REQ-017 Cfg_ready SHALL be 1 only in IDLE; handshake latches Cfg_key/Cfg_iv into registers that next cycle.
REQ-018 IDLE->KEY when cfg_loaded=1, S_axis_tvalid=1 and no config handshake in the same cycle; simultaneous Cfg and payload valid: config taken first, KEY entered one cycle later using the new config.
REQ-019 IDLE: S_axis_tready=0, M_axis_tvalid=0.
REQ-020 KEY: emit 256/AXIS_WIDTH beats; beat k tdata = key_reg[k*W +: W]; advance on M handshake only.
REQ-021 IV: emit 128/AXIS_WIDTH beats; beat k tdata = iv_reg[k*W +: W] (byte 0 of IV in tdata[7:0] of first beat).
REQ-022 Header beats: M_axis_tkeep all ones, M_axis_tlast=0, S_axis_tready=0; tdata held stable while tvalid & !tready.
REQ-023 KEY->IV after last key beat handshake; IV->PAYLOAD after last IV beat handshake; beat counter resets to 0 at each transition.
REQ-024 PAYLOAD: zero-latency combinational pass-through: M_axis_tvalid=S_axis_tvalid, S_axis_tready=M_axis_tready, tdata/tkeep/tlast copied unmodified.
REQ-025 PAYLOAD->IDLE on M handshake with tlast=1; Pkt_count increments in that same cycle.
REQ-026 Every packet re-sends full key and IV header (core returns to key state after each tlast); key/IV registers unchanged between packets unless reconfigured.
REQ-027 M_axis_tuser = ENCRYPT_FLAG on all beats while M_axis_tvalid=1; all M outputs 0 when M_axis_tvalid=0.
REQ-028 Payload packets carry >=1 beat; a single-beat packet with tlast yields header + 1 beat.
REQ-029 Config writes during a packet are impossible (Cfg_ready=0); Cfg_valid held by source until IDLE.

Reset
REQ-030 Rst=1 at any edge, including mid-header or mid-payload: state=IDLE, beat counter=0, cfg_loaded=0, key_reg=0, iv_reg=0, Pkt_count=0.
REQ-031 During and after reset until next config: Cfg_ready=1 (IDLE), S_axis_tready=0, M_axis_tvalid=0, M_axis_tlast=0, M_axis_tuser=0, Busy=0.
REQ-032 Partially sent packet aborted by reset is not resumed; the downstream core is reset by the same Rst.

Verification
REQ-033 W=64, key=0x1F1E..00, iv=0xFFEEDDCCBBAA99887766554433221100, 2-beat payload, tready=1 -> 8 M beats: 4 key words (first 0x0706050403020100), iv words 0x7766554433221100, 0xFFEEDDCCBBAA9988, then payload; tlast on beat 8; Pkt_count=1.
REQ-034 Payload valid with no config after reset -> S_axis_tready stays 0, M_axis_tvalid stays 0 for 20 cycles; Busy=0.
REQ-035 M_axis_tready toggling 1010... during header -> each header word held until accepted, no word skipped or duplicated; total 6 header handshakes.
REQ-036 Cfg_valid and S_axis_tvalid asserted same cycle in IDLE with new key -> first key beat carries the new key's bytes 0..7.
REQ-037 Rst pulsed during second IV beat -> next cycle IDLE, M_axis_tvalid=0, Pkt_count=0; payload blocked until new config.
REQ-038 Back-to-back 3 packets, last beat tkeep=0x0F, W=128 variant -> each packet preceded by 2 key + 1 IV beat, tkeep 0x0F passed unchanged, Pkt_count=3.

Source files
------------

// File: rtl/aes_ctr_header_framer_if.sv
// Stream and configuration bundle between a key/IV source, the payload source,
// the header framer and the downstream AES-CTR core.
interface aes_ctr_header_framer_if #(
    parameter int AXIS_WIDTH = 64
);
    logic                    Cfg_valid;
    logic                    Cfg_ready;
    logic [255:0]            Cfg_key;
    logic [127:0]            Cfg_iv;

    logic                    S_axis_tvalid;
    logic                    S_axis_tready;
    logic [AXIS_WIDTH-1:0]   S_axis_tdata;
    logic [AXIS_WIDTH/8-1:0] S_axis_tkeep;
    logic                    S_axis_tlast;

    logic                    M_axis_tvalid;
    logic                    M_axis_tready;
    logic [AXIS_WIDTH-1:0]   M_axis_tdata;
    logic [AXIS_WIDTH/8-1:0] M_axis_tkeep;
    logic                    M_axis_tlast;
    logic                    M_axis_tuser;

    // Framer side
    modport slave (
        input  Cfg_valid, Cfg_key, Cfg_iv,
        output Cfg_ready,
        input  S_axis_tvalid, S_axis_tdata, S_axis_tkeep, S_axis_tlast,
        output S_axis_tready,
        output M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser,
        input  M_axis_tready
    );

    // Environment side (config source, payload source and downstream core)
    modport master (
        output Cfg_valid, Cfg_key, Cfg_iv,
        input  Cfg_ready,
        output S_axis_tvalid, S_axis_tdata, S_axis_tkeep, S_axis_tlast,
        input  S_axis_tready,
        input  M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser,
        output M_axis_tready
    );
endinterface

// File: rtl/aes_ctr_header_framer.sv
// Prefixes every payload packet with the 256-bit key and 128-bit IV as header
// beats, then passes the payload through combinationally to the CTR core.
module aes_ctr_header_framer #(
    parameter int AXIS_WIDTH   = 64,
    parameter bit ENCRYPT_FLAG = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    aes_ctr_header_framer_if.slave bus,
    output logic                   Busy,
    output logic [15:0]            Pkt_count
);
    localparam int         KEY_BEATS = 256 / AXIS_WIDTH;
    localparam int         IV_BEATS  = 128 / AXIS_WIDTH;
    localparam logic [1:0] KEY_LAST  = 2'(KEY_BEATS - 1);
    localparam logic [1:0] IV_LAST   = 2'(IV_BEATS - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        KEY     = 4'b0010,
        IV      = 4'b0100,
        PAYLOAD = 4'b1000
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_beat;
    logic                  r_cfg_loaded;
    logic [255:0]          r_key;
    logic [127:0]          r_iv;
    logic [15:0]           r_pkt_count;

    logic                  w_cfg_ready;
    logic                  w_cfg_hs;
    logic                  w_m_valid;
    logic                  w_m_hs;
    logic                  w_pkt_done;
    logic [AXIS_WIDTH-1:0] w_key_words [4];
    logic [AXIS_WIDTH-1:0] w_iv_words  [4];

    // Word tables padded to four entries so the 2-bit beat counter indexes them exactly
    for (genvar gi = 0; gi < 4; gi++) begin : g_words
        if (gi < KEY_BEATS) begin : g_key
            assign w_key_words[gi] = r_key[gi*AXIS_WIDTH +: AXIS_WIDTH];
        end else begin : g_key_pad
            assign w_key_words[gi] = '0;
        end
        if (gi < IV_BEATS) begin : g_iv
            assign w_iv_words[gi] = r_iv[gi*AXIS_WIDTH +: AXIS_WIDTH];
        end else begin : g_iv_pad
            assign w_iv_words[gi] = '0;
        end
    end

    assign w_cfg_hs   = bus.Cfg_valid & w_cfg_ready;
    assign w_m_hs     = w_m_valid & bus.M_axis_tready;
    assign w_pkt_done = (r_state == PAYLOAD) & w_m_hs & bus.S_axis_tlast;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // A config handshake in the same cycle wins; the packet starts next cycle
            IDLE:    if (r_cfg_loaded && bus.S_axis_tvalid && !w_cfg_hs) w_state_next = KEY;
            KEY:     if (w_m_hs && r_beat == KEY_LAST) w_state_next = IV;
            IV:      if (w_m_hs && r_beat == IV_LAST)  w_state_next = PAYLOAD;
            PAYLOAD: if (w_pkt_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_cfg_ready       = 1'b0;
        w_m_valid         = 1'b0;
        bus.S_axis_tready = 1'b0;
        bus.M_axis_tdata  = '0;
        bus.M_axis_tkeep  = '0;
        bus.M_axis_tlast  = 1'b0;
        case (r_state)
            IDLE: w_cfg_ready = 1'b1;
            KEY: begin
                w_m_valid        = 1'b1;
                bus.M_axis_tdata = w_key_words[r_beat];
                bus.M_axis_tkeep = '1;
            end
            IV: begin
                w_m_valid        = 1'b1;
                bus.M_axis_tdata = w_iv_words[r_beat];
                bus.M_axis_tkeep = '1;
            end
            PAYLOAD: begin
                w_m_valid         = bus.S_axis_tvalid;
                bus.S_axis_tready = bus.M_axis_tready;
                if (bus.S_axis_tvalid) begin
                    bus.M_axis_tdata = bus.S_axis_tdata;
                    bus.M_axis_tkeep = bus.S_axis_tkeep;
                    bus.M_axis_tlast = bus.S_axis_tlast;
                end
            end
            default: w_cfg_ready = 1'b0;
        endcase
        bus.Cfg_ready     = w_cfg_ready;
        bus.M_axis_tvalid = w_m_valid;
        bus.M_axis_tuser  = w_m_valid ? ENCRYPT_FLAG : 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_beat       <= '0;
            r_cfg_loaded <= 1'b0;
            r_key        <= '0;
            r_iv         <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (r_state != w_state_next) begin
                r_beat <= '0;
            end else if ((r_state == KEY || r_state == IV) && w_m_hs) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_cfg_hs) begin
                r_cfg_loaded <= 1'b1;
                r_key        <= bus.Cfg_key;
                r_iv         <= bus.Cfg_iv;
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign Busy      = (r_state != IDLE);
    assign Pkt_count = r_pkt_count;
endmodule

// File: tb/tb_aes_ctr_header_framer.sv
// Scoreboard bench for the header framer: 64-bit instance for the main scenarios,
// 128-bit instance for back-to-back packets with a partial last beat.
module tb_aes_ctr_header_framer;
    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    aes_ctr_header_framer_if #(.AXIS_WIDTH(64))  if64();
    aes_ctr_header_framer_if #(.AXIS_WIDTH(128)) if128();
    logic        Busy64, Busy128;
    logic [15:0] Pkt64, Pkt128;

    aes_ctr_header_framer #(.AXIS_WIDTH(64), .ENCRYPT_FLAG(1'b1)) u_dut64 (
        .Clk(Clk), .Rst(Rst), .bus(if64), .Busy(Busy64), .Pkt_count(Pkt64));
    aes_ctr_header_framer #(.AXIS_WIDTH(128), .ENCRYPT_FLAG(1'b1)) u_dut128 (
        .Clk(Clk), .Rst(Rst), .bus(if128), .Busy(Busy128), .Pkt_count(Pkt128));

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    beat_t q64[$];
    beat_t q128[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    hs64 = 0, hdr64 = 0, hs128 = 0, hdr128 = 0;
    bit    tog64 = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream monitor, 64-bit instance
    logic [63:0] prev64;
    bit          stall64 = 1'b0;
    always @(negedge Clk) begin : mon64
        beat_t e;
        if (Rst) begin
            stall64 = 1'b0;
        end else if (if64.M_axis_tvalid) begin
            if (stall64) check("m64_hold", {64'b0, if64.M_axis_tdata}, {64'b0, prev64});
            check("m64_tuser", {127'b0, if64.M_axis_tuser}, 128'd1);
            if (if64.M_axis_tready) begin
                hs64++;
                if (!if64.S_axis_tready) hdr64++;
                if (q64.size() == 0) begin
                    check("m64_extra_beat", q64.size(), 1);
                end else begin
                    e = q64.pop_front();
                    $display("m64 beat data=%h keep=%h last=%0d", if64.M_axis_tdata, if64.M_axis_tkeep, if64.M_axis_tlast);
                    check("m64_tdata", {64'b0, if64.M_axis_tdata}, e.data);
                    check("m64_tkeep", {120'b0, if64.M_axis_tkeep}, {112'b0, e.keep});
                    check("m64_tlast", {127'b0, if64.M_axis_tlast}, {127'b0, e.last});
                end
            end
            stall64 = !if64.M_axis_tready;
            prev64  = if64.M_axis_tdata;
        end else begin
            check("m64_idle_out", {54'b0, if64.M_axis_tdata, if64.M_axis_tkeep, if64.M_axis_tlast, if64.M_axis_tuser}, 128'd0);
            stall64 = 1'b0;
        end
    end

    // Downstream monitor, 128-bit instance
    always @(negedge Clk) begin : mon128
        beat_t e;
        if (!Rst && if128.M_axis_tvalid && if128.M_axis_tready) begin
            hs128++;
            if (!if128.S_axis_tready) hdr128++;
            check("m128_tuser", {127'b0, if128.M_axis_tuser}, 128'd1);
            if (q128.size() == 0) begin
                check("m128_extra_beat", q128.size(), 1);
            end else begin
                e = q128.pop_front();
                $display("m128 beat data=%h keep=%h last=%0d", if128.M_axis_tdata, if128.M_axis_tkeep, if128.M_axis_tlast);
                check("m128_tdata", if128.M_axis_tdata, e.data);
                check("m128_tkeep", {112'b0, if128.M_axis_tkeep}, {112'b0, e.keep});
                check("m128_tlast", {127'b0, if128.M_axis_tlast}, {127'b0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (tog64) if64.M_axis_tready = ~if64.M_axis_tready;
    endtask

    task automatic push_exp64(input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t e;
        e.data = {64'b0, d};
        e.keep = {8'b0, k};
        e.last = l;
        q64.push_back(e);
    endtask

    task automatic push_hdr64(input logic [255:0] key, input logic [127:0] iv);
        for (int k = 0; k < 4; k++) push_exp64(key[k*64 +: 64], 8'hFF, 1'b0);
        for (int k = 0; k < 2; k++) push_exp64(iv[k*64 +: 64], 8'hFF, 1'b0);
    endtask

    task automatic cfg64(input logic [255:0] key, input logic [127:0] iv);
        bit ok = 1'b0;
        if64.Cfg_key   = key;
        if64.Cfg_iv    = iv;
        if64.Cfg_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge Clk);
            ok = if64.Cfg_ready;
            @(posedge Clk);
            #1;
        end
        if64.Cfg_valid = 1'b0;
        check("cfg64_accept", {127'b0, ok}, 128'd1);
    endtask

    task automatic send_pay64(input int nb, input logic [7:0] last_keep);
        for (int b = 0; b < nb; b++) begin
            bit ok = 1'b0;
            if64.S_axis_tdata  = {$urandom, $urandom};
            if64.S_axis_tkeep  = (b == nb - 1) ? last_keep : 8'hFF;
            if64.S_axis_tlast  = (b == nb - 1);
            if64.S_axis_tvalid = 1'b1;
            push_exp64(if64.S_axis_tdata, if64.S_axis_tkeep, if64.S_axis_tlast);
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge Clk);
                ok = if64.S_axis_tready;
                tick();
            end
            check("s64_accept", {127'b0, ok}, 128'd1);
        end
        if64.S_axis_tvalid = 1'b0;
        if64.S_axis_tlast  = 1'b0;
    endtask

    task automatic drain64(input logic [15:0] exp_pkts);
        for (int i = 0; i < 300 && (q64.size() != 0 || Busy64); i++) tick();
        check("drain64_left", q64.size(), 0);
        check("busy64_after", {127'b0, Busy64}, 128'd0);
        check("pkt64", {112'b0, Pkt64}, {112'b0, exp_pkts});
    endtask

    task automatic push_hdr128(input logic [255:0] key, input logic [127:0] iv);
        beat_t e;
        e.keep = 16'hFFFF;
        e.last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e.data = key[k*128 +: 128];
            q128.push_back(e);
        end
        e.data = iv;
        q128.push_back(e);
    endtask

    task automatic send_pay128(input int nb, input logic [15:0] last_keep);
        beat_t e;
        for (int b = 0; b < nb; b++) begin
            bit ok = 1'b0;
            if128.S_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            if128.S_axis_tkeep  = (b == nb - 1) ? last_keep : 16'hFFFF;
            if128.S_axis_tlast  = (b == nb - 1);
            if128.S_axis_tvalid = 1'b1;
            e.data = if128.S_axis_tdata;
            e.keep = if128.S_axis_tkeep;
            e.last = if128.S_axis_tlast;
            q128.push_back(e);
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge Clk);
                ok = if128.S_axis_tready;
                @(posedge Clk);
                #1;
            end
            check("s128_accept", {127'b0, ok}, 128'd1);
        end
        if128.S_axis_tvalid = 1'b0;
        if128.S_axis_tlast  = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [255:0] key_a, key_b, key_c;
        logic [127:0] iv_a, iv_c;
        int base, hbase;
        bit reached;

        for (int i = 0; i < 32; i++) key_a[i*8 +: 8] = 8'(i);
        iv_a = 128'hFFEEDDCCBBAA99887766554433221100;
        for (int i = 0; i < 8; i++) key_b[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) key_c[i*32 +: 32] = $urandom;
        iv_c = {$urandom, $urandom, $urandom, $urandom};

        Rst = 1'b1;
        if64.Cfg_valid = 1'b0;      if64.Cfg_key = '0;       if64.Cfg_iv = '0;
        if64.S_axis_tvalid = 1'b0;  if64.S_axis_tdata = '0;  if64.S_axis_tkeep = '0;
        if64.S_axis_tlast = 1'b0;   if64.M_axis_tready = 1'b1;
        if128.Cfg_valid = 1'b0;     if128.Cfg_key = '0;      if128.Cfg_iv = '0;
        if128.S_axis_tvalid = 1'b0; if128.S_axis_tdata = '0; if128.S_axis_tkeep = '0;
        if128.S_axis_tlast = 1'b0;  if128.M_axis_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_cfg_ready", {127'b0, if64.Cfg_ready}, 128'd1);
        check("rst_s_ready",   {127'b0, if64.S_axis_tready}, 128'd0);
        check("rst_m_valid",   {127'b0, if64.M_axis_tvalid}, 128'd0);
        check("rst_m_tlast",   {127'b0, if64.M_axis_tlast}, 128'd0);
        check("rst_m_tuser",   {127'b0, if64.M_axis_tuser}, 128'd0);
        check("rst_busy",      {127'b0, Busy64}, 128'd0);
        check("rst_pkt",       {112'b0, Pkt64}, 128'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Payload without any configuration is blocked
        if64.S_axis_tvalid = 1'b1;
        if64.S_axis_tdata  = 64'hDEAD_BEEF_0123_4567;
        if64.S_axis_tkeep  = 8'hFF;
        if64.S_axis_tlast  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("nocfg_block", {125'b0, if64.S_axis_tready, if64.M_axis_tvalid, Busy64}, 128'd0);
            tick();
        end
        if64.S_axis_tvalid = 1'b0;
        if64.S_axis_tlast  = 1'b0;

        // Reference packet: literal header words, 2-beat payload
        cfg64(key_a, iv_a);
        push_exp64(64'h0706050403020100, 8'hFF, 1'b0);
        push_exp64(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
        push_exp64(64'h1716151413121110, 8'hFF, 1'b0);
        push_exp64(64'h1F1E1D1C1B1A1918, 8'hFF, 1'b0);
        push_exp64(64'h7766554433221100, 8'hFF, 1'b0);
        push_exp64(64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0);
        base = hs64;
        send_pay64(2, 8'hFF);
        drain64(16'd1);
        check("ref_beats", hs64 - base, 8);

        // Backpressure toggling 1010... during header and payload
        tog64 = 1'b1;
        base  = hs64;
        hbase = hdr64;
        push_hdr64(key_a, iv_a);
        send_pay64(3, 8'h3F);
        drain64(16'd2);
        tog64 = 1'b0;
        if64.M_axis_tready = 1'b1;
        check("bp_hdr_hs", hdr64 - hbase, 6);
        check("bp_total_hs", hs64 - base, 9);

        // Config and payload offered together: new key must head the packet
        push_hdr64(key_b, iv_a);
        fork
            cfg64(key_b, iv_a);
            send_pay64(1, 8'h01);
        join
        drain64(16'd3);

        // Reset while the second IV beat is presented
        push_hdr64(key_b, iv_a);
        if64.S_axis_tdata  = 64'h0BAD_F00D_0BAD_F00D;
        if64.S_axis_tkeep  = 8'hFF;
        if64.S_axis_tlast  = 1'b1;
        if64.S_axis_tvalid = 1'b1;
        base    = hs64;
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            tick();
            reached = (hs64 - base >= 5);
        end
        check("rst_mid_reach", hs64 - base, 5);
        if64.M_axis_tready = 1'b0;
        Rst = 1'b1;
        q64.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        if64.M_axis_tready = 1'b1;
        @(negedge Clk);
        check("rst_mid_m_valid", {127'b0, if64.M_axis_tvalid}, 128'd0);
        check("rst_mid_busy",    {127'b0, Busy64}, 128'd0);
        check("rst_mid_pkt",     {112'b0, Pkt64}, 128'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge Clk);
            check("rst_mid_block", {126'b0, if64.S_axis_tready, if64.M_axis_tvalid}, 128'd0);
        end
        @(posedge Clk);
        #1;
        if64.S_axis_tvalid = 1'b0;
        if64.S_axis_tlast  = 1'b0;

        // 128-bit instance: three back-to-back packets, partial last beat
        if128.Cfg_key   = key_c;
        if128.Cfg_iv    = iv_c;
        if128.Cfg_valid = 1'b1;
        @(posedge Clk);
        #1;
        if128.Cfg_valid = 1'b0;
        base  = hs128;
        hbase = hdr128;
        for (int p = 0; p < 3; p++) begin
            push_hdr128(key_c, iv_c);
            send_pay128(2, 16'h000F);
        end
        for (int i = 0; i < 300 && (q128.size() != 0 || Busy128); i++) begin
            @(posedge Clk);
            #1;
        end
        check("drain128_left", q128.size(), 0);
        check("pkt128", {112'b0, Pkt128}, 128'd3);
        check("b2b_hdr_hs", hdr128 - hbase, 9);
        check("b2b_total_hs", hs128 - base, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
